// File: rtl/xor_pattern_sequencer.sv
// xor_pattern_sequencer: drives a quad XOR stage through its four truth-table phases and checks its outputs
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    run request, accepted only in IDLE
//   y_in     XOR outputs {y4,y3,y2,y1}
//   op_a     first operands {d1,c1,b1,a1}
//   op_b     second operands {d2,c2,b2,a2}
//   phase    current phase 0..3, 0 outside DRIVE
//   busy     high while driving phases
//   done     one-cycle pulse at end of run
//   pass     last completed run had no mismatch
//   err_mask sticky per-lane mismatch flags
module xor_pattern_sequencer #(
    parameter int LANES         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LANES-1:0] y_in,
    output logic [LANES-1:0] op_a,
    output logic [LANES-1:0] op_b,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LANES-1:0] err_mask
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    logic [1:0]       state;
    logic [7:0]       cnt;
    logic             last;
    logic [1:0]       nph;
    logic [LANES-1:0] exp_y;
    logic [LANES-1:0] err_next;
    assign last     = cnt == 8'(SETTLE_CYCLES - 1);
    assign nph      = phase + 2'd1;
    // phase bit0 selects op_a, bit1 selects op_b, so the expected XOR is their parity
    assign exp_y    = {LANES{phase[0] ^ phase[1]}};
    assign err_next = err_mask | (y_in ^ exp_y);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            phase    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_DRIVE;
                    phase    <= '0;
                    cnt      <= '0;
                    err_mask <= '0;
                    pass     <= 1'b0;
                    busy     <= 1'b1;
                    op_a     <= '0;
                    op_b     <= '0;
                end
                S_DRIVE: if (!last) begin
                    cnt <= cnt + 8'd1;
                end else begin
                    err_mask <= err_next;
                    cnt      <= '0;
                    if (phase == 2'd3) begin
                        state <= S_DONE;
                        phase <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_next == '0;
                        op_a  <= '0;
                        op_b  <= '0;
                    end else begin
                        phase <= nph;
                        op_a  <= {LANES{nph[0]}};
                        op_b  <= {LANES{nph[1]}};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_pattern_sequencer.sv
// tb_xor_pattern_sequencer: directed and randomized checks of the XOR pattern sequencer against a phase-table model
module tb_xor_pattern_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start [2];
    logic [3:0] y [2];
    logic [3:0] yd [2];
    logic [3:0] op_a [2];
    logic [3:0] op_b [2];
    logic [3:0] err_mask [2];
    logic [1:0] phase [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [3:0] s0 = 4'd0;
    logic [3:0] s1 = 4'd0;
    bit         dly = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         dc;
    logic [3:0] pa [4] = '{4'h0, 4'hF, 4'h0, 4'hF};
    logic [3:0] pb [4] = '{4'h0, 4'h0, 4'hF, 4'hF};

    always #5 clk = ~clk;

    xor_pattern_sequencer #(.LANES(4), .SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .y_in(y[0]), .op_a(op_a[0]), .op_b(op_b[0]),
        .phase(phase[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_mask(err_mask[0]));
    xor_pattern_sequencer #(.LANES(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .y_in(y[1]), .op_a(op_a[1]), .op_b(op_b[1]),
        .phase(phase[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_mask(err_mask[1]));

    // XOR stage model: either combinational with stuck-at faults, or registered (one cycle late)
    always @(posedge clk) begin
        yd[0] <= op_a[0] ^ op_b[0];
        yd[1] <= op_a[1] ^ op_b[1];
    end
    assign y[0] = dly ? yd[0] : (((op_a[0] ^ op_b[0]) & ~s0) | s1);
    assign y[1] = dly ? yd[1] : (((op_a[1] ^ op_b[1]) & ~s0) | s1);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected final mask: what each phase's sample sees versus the true XOR of that phase
    function automatic logic [3:0] model(input int sc, input bit d, input logic [3:0] f0, input logic [3:0] f1);
        logic [3:0] err = '0;
        logic [3:0] prev = '0;
        logic [3:0] x;
        logic [3:0] obs;
        for (int p = 0; p < 4; p++) begin
            x = pa[p] ^ pb[p];
            obs = d ? ((sc == 1) ? prev : x) : ((x & ~f0) | f1);
            err |= obs ^ x;
            prev = x;
        end
        return err;
    endfunction

    task automatic run(input int i, input bit inj, input logic [3:0] e);
        int sc;
        sc = (i == 1) ? 1 : 2;
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        for (int k = 0; k < 4 * sc; k++) begin
            chk("busy", 8'(busy[i]), 8'd1);
            chk("done_in_run", 8'(done[i]), 8'd0);
            chk("op_a", 8'(op_a[i]), 8'(pa[k / sc]));
            chk("op_b", 8'(op_b[i]), 8'(pb[k / sc]));
            chk("phase", 8'(phase[i]), 8'(k / sc));
            if (k == 0) begin
                chk("err_cleared", 8'(err_mask[i]), 8'd0);
                chk("pass_cleared", 8'(pass[i]), 8'd0);
            end
            start[i] = inj && k == 4;
            @(negedge clk);
        end
        start[i] = 1'b0;
        chk("done_pulse", 8'(done[i]), 8'd1);
        chk("busy_done", 8'(busy[i]), 8'd0);
        chk("err_mask", 8'(err_mask[i]), 8'(e));
        chk("pass", 8'(pass[i]), 8'(e == 4'd0));
        chk("op_a_done", 8'(op_a[i]), 8'd0);
        chk("op_b_done", 8'(op_b[i]), 8'd0);
        start[i] = inj;
        @(negedge clk);
        start[i] = 1'b0;
        chk("done_once", 8'(done[i]), 8'd0);
        chk("busy_idle", 8'(busy[i]), 8'd0);
        chk("err_hold", 8'(err_mask[i]), 8'(e));
        chk("pass_hold", 8'(pass[i]), 8'(e == 4'd0));
        @(negedge clk);
        chk("no_restart", 8'(busy[i]), 8'd0);
    endtask

    initial begin
        logic [3:0] e;
        int i;
        start[0] = 1'b0;
        start[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            chk("rst_op_a", 8'(op_a[j]), 8'd0);
            chk("rst_busy", 8'(busy[j]), 8'd0);
            chk("rst_done", 8'(done[j]), 8'd0);
            chk("rst_pass", 8'(pass[j]), 8'd0);
            chk("rst_err", 8'(err_mask[j]), 8'd0);
            chk("rst_phase", 8'(phase[j]), 8'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b0, model(2, 1'b0, 4'd0, 4'd0));
        s0 = 4'b0100;
        run(0, 1'b0, model(2, 1'b0, s0, s1));
        s0 = 4'd0;
        run(0, 1'b1, model(2, 1'b0, s0, s1));
        dly = 1'b1;
        run(0, 1'b0, model(2, 1'b1, 4'd0, 4'd0));
        run(1, 1'b0, model(1, 1'b1, 4'd0, 4'd0));
        dly = 1'b0;
        repeat (8) begin
            s0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            s1 = ($urandom_range(0, 2) == 0) ? 4'd0 : (4'($urandom) & ~s0);
            i = $urandom_range(0, 1);
            run(i, 1'b0, model((i == 1) ? 1 : 2, 1'b0, s0, s1));
        end
        s0 = 4'd0;
        s1 = 4'b0001;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int t = 0; t < 20 && phase[0] != 2'd2; t++) @(negedge clk);
        chk("reach_phase2", 8'(phase[0]), 8'd2);
        chk("err_before_rst", 8'(err_mask[0]), 8'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_op_a", 8'(op_a[0]), 8'd0);
        chk("async_op_b", 8'(op_b[0]), 8'd0);
        chk("async_busy", 8'(busy[0]), 8'd0);
        chk("async_err", 8'(err_mask[0]), 8'd0);
        chk("async_pass", 8'(pass[0]), 8'd0);
        rst_n = 1'b1;
        s1 = 4'd0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            chk("post_rst_done", 8'(done[0]), 8'd0);
            chk("post_rst_busy", 8'(busy[0]), 8'd0);
        end
        dc = 0;
        start[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("b2b_done", 8'(done[0]), 8'(c % 10 == 9));
            if (done[0]) begin
                dc++;
                chk("b2b_pass", 8'(pass[0]), 8'd1);
            end
        end
        start[0] = 1'b0;
        chk("b2b_count", 8'(dc), 8'd3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
